// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state type used by the transmitter and by
// the collector's receivers.
package uart_pkg;

    localparam int DATA_W         = 8;
    localparam int CPB_SLOW_DEF   = 16;
    localparam int CPB_FAST_DEF   = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; the head byte is
// presented combinationally so a pop can load it on the same edge.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push_ok;
    logic              pop_ok;

    // Full is judged on the pre-edge count, so a write into a full FIFO is
    // refused even if a pop frees a slot on the same edge.
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)
                count <= count + 1'b1;
            else if (pop_ok && !push_ok)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= i_data;
    end

    assign o_head  = mem[rd_ptr];
    assign o_full  = (count == CNT_W'(DEPTH));
    assign o_empty = (count == '0);

endmodule

// File: rtl/uart_frame_tx.sv
// Buffered 8N1 UART transmitter with per-frame baud select. Define
// UART_FRAME_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CPB_SLOW   = CPB_SLOW_DEF,
    parameter int CPB_FAST   = CPB_FAST_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_D,
    input  logic              i_write,
    input  logic              i_baud,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_overflow
);

    localparam int CPB_MAX = (CPB_SLOW > CPB_FAST) ? CPB_SLOW : CPB_FAST;
    localparam int BCNT_W  = (CPB_MAX > 1) ? $clog2(CPB_MAX) : 1;
    localparam logic [BCNT_W-1:0] SLOW_LAST = BCNT_W'(CPB_SLOW - 1);
    localparam logic [BCNT_W-1:0] FAST_LAST = BCNT_W'(CPB_FAST - 1);

    tx_state_t         state;
    logic [BCNT_W-1:0] baud_cnt;
    logic [BCNT_W-1:0] cpb_last;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] shifter;
    logic [DATA_W-1:0] head;
    logic              bit_end;
    logic              pop;
`ifdef UART_FRAME_TX_PARITY_EN
    logic              par_bit;
`endif

    assign bit_end = (baud_cnt == cpb_last);
    // A pop at the end of STOP chains the next frame with no idle gap.
    assign pop = !o_empty && ((state == ST_IDLE) || (state == ST_STOP && bit_end));

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_write),
        .i_pop   (pop),
        .i_data  (i_D),
        .o_head  (head),
        .o_full  (o_full),
        .o_empty (o_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) o_overflow <= 1'b0;
        else        o_overflow <= i_write && o_full;
    end

    always_ff @(posedge i_clk) begin
        if (pop)
            shifter <= head;
        else if (state == ST_DATA && bit_end)
            shifter <= shifter >> 1;
`ifdef UART_FRAME_TX_PARITY_EN
        if (pop) par_bit <= even_parity(head);
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= ST_IDLE;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            cpb_last <= SLOW_LAST;
        end else if (pop) begin
            state    <= ST_START;
            o_tx     <= 1'b0;
            o_busy   <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            cpb_last <= i_baud ? FAST_LAST : SLOW_LAST;
        end else begin
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                end
                ST_START: begin
                    if (bit_end) begin
                        state <= ST_DATA;
                        o_tx  <= shifter[0];
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef UART_FRAME_TX_PARITY_EN
                            state   <= ST_PARITY;
                            o_tx    <= par_bit;
`else
                            state   <= ST_STOP;
                            o_tx    <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            o_tx    <= shifter[1];
                        end
                    end
                end
`ifdef UART_FRAME_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state <= ST_STOP;
                        o_tx  <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    // Non-empty FIFO at STOP end is handled by the pop branch.
                    if (bit_end) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: queued bytes are decoded off o_tx and
// compared bit by bit, including exact per-bit cycle counts.
module tb_uart_frame_tx;

`ifdef UART_FRAME_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    typedef struct {
        logic [7:0] data;
        int         cpb;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       wr;
    logic       baud;
    logic       tx;
    logic       busy;
    logic       full;
    logic       empty;
    logic       ovf;

    int   checks;
    int   errors;
    exp_t sb[$];
    int   gaps[$];
    int   frames;
    bit   in_frame;

    uart_frame_tx dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_D        (din),
        .i_write    (wr),
        .i_baud     (baud),
        .o_tx       (tx),
        .o_busy     (busy),
        .o_full     (full),
        .o_empty    (empty),
        .o_overflow (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (NBITS == 11 && idx == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic monitor();
        exp_t cur;
        int   bit_i;
        int   cyc;
        int   gap;
        bit   bad;
        cur = '{data: 8'h00, cpb: 1};
        bit_i = 0; cyc = 0; gap = 0; bad = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 0;
                gap = 0;
            end else begin
                if (!in_frame && tx === 1'b0) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_start: o_tx=0 at %0t with no byte queued, required 1", $time);
                    end else begin
                        cur = sb.pop_front();
                        in_frame = 1;
                        bit_i = 0; cyc = 0; bad = 0;
                        gaps.push_back(gap);
                        frames++;
                    end
                end
                if (in_frame) begin
                    if (tx !== frame_bit(cur.data, bit_i)) bad = 1;
                    cyc++;
                    if (cyc == cur.cpb) begin
                        checks++;
                        if (bad) begin
                            errors++;
                            $display("FAIL frame_bit byte=%02h bit=%0d: o_tx deviated within %0d-cycle bit, required %b",
                                     cur.data, bit_i, cur.cpb, frame_bit(cur.data, bit_i));
                        end
                        bit_i++; cyc = 0; bad = 0;
                        if (bit_i == NBITS) begin
                            in_frame = 0;
                            gap = 0;
                        end
                    end
                end else begin
                    gap++;
                end
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !in_frame && busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input int cpb);
        din = d;
        wr  = 1'b1;
        sb.push_back('{data: d, cpb: cpb});
    endtask

    task automatic test_reset();
        #12;
        checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b, required 1", tx); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (full !== 1'b0)  begin errors++; $display("FAIL reset_full: got %b, required 0", full); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b, required 1", empty); end
        checks++; if (ovf !== 1'b0)   begin errors++; $display("FAIL reset_overflow: got %b, required 0", ovf); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        int busy_cycles;
        int f0;
        bit ok;
        f0 = frames;
        baud = 1'b0;
        push_byte(8'hA5, 16);
        @(posedge clk); #1;
        wr = 1'b0;
        checks++; if (tx !== 1'b1 || empty !== 1'b0) begin
            errors++; $display("FAIL single_after_write: tx=%b empty=%b, required tx=1 empty=0", tx, empty);
        end
        @(posedge clk); #1;
        checks++; if (tx !== 1'b0 || busy !== 1'b1 || empty !== 1'b1) begin
            errors++; $display("FAIL single_start_latency: tx=%b busy=%b empty=%b, required 0 1 1", tx, busy, empty);
        end
        busy_cycles = 1;
        for (int i = 0; i < 400 && busy === 1'b1; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b1) busy_cycles++;
        end
        checks++; if (busy_cycles != NBITS * 16) begin
            errors++; $display("FAIL single_busy_len: got %0d cycles, required %0d", busy_cycles, NBITS * 16);
        end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_done: timeout, %0d bytes pending", sb.size()); end
        checks++; if (frames - f0 != 1) begin errors++; $display("FAIL single_frames: got %0d, required 1", frames - f0); end
    endtask

    task automatic test_back_to_back();
        int f0;
        bit ok;
        f0 = frames;
        baud = 1'b1;
        push_byte(8'h00, 8);
        @(posedge clk); #1;
        push_byte(8'hFF, 8);
        @(posedge clk); #1;
        wr = 1'b0;
        wait_done(ok);
        baud = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL b2b_done: timeout, %0d bytes pending", sb.size()); end
        checks++; if (frames - f0 != 2) begin errors++; $display("FAIL b2b_frames: got %0d, required 2", frames - f0); end
        checks++; if (gaps.size() == 0 || gaps[gaps.size()-1] != 0) begin
            errors++; $display("FAIL b2b_gap: got %0d idle cycles, required 0", (gaps.size() == 0) ? -1 : gaps[gaps.size()-1]);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] vals [6];
        int f0;
        bit ok;
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        f0 = frames;
        baud = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din = vals[i];
            wr  = 1'b1;
            if (i < 5) sb.push_back('{data: vals[i], cpb: 8});
            @(posedge clk); #1;
            if (i == 3) begin
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_full_early: got %b, required 0", full); end
            end
            if (i == 4) begin
                checks++; if (full !== 1'b1 || ovf !== 1'b0) begin
                    errors++; $display("FAIL ovf_full_5th: full=%b overflow=%b, required 1 0", full, ovf);
                end
            end
            if (i == 5) begin
                checks++; if (ovf !== 1'b1 || full !== 1'b1) begin
                    errors++; $display("FAIL ovf_pulse: overflow=%b full=%b, required 1 1", ovf, full);
                end
            end
        end
        wr = 1'b0;
        @(posedge clk); #1;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_pulse_len: got %b, required 0", ovf); end
        wait_done(ok);
        baud = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL ovf_done: timeout, %0d bytes pending", sb.size()); end
        checks++; if (frames - f0 != 5) begin errors++; $display("FAIL ovf_frames: got %0d, required 5", frames - f0); end
    endtask

    task automatic test_baud_change();
        int f0;
        bit ok;
        f0 = frames;
        baud = 1'b0;
        push_byte(8'h3C, 16);
        @(posedge clk); #1;
        push_byte(8'h5A, 8);
        @(posedge clk); #1;
        wr = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        baud = 1'b1;
        wait_done(ok);
        baud = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL baud_done: timeout, %0d bytes pending", sb.size()); end
        checks++; if (frames - f0 != 2) begin errors++; $display("FAIL baud_frames: got %0d, required 2", frames - f0); end
    endtask

    task automatic test_reset_mid_frame();
        bit line_high;
        bit never_busy;
        baud = 1'b0;
        push_byte(8'h35, 16);
        @(posedge clk); #1;
        push_byte(8'h99, 16);
        @(posedge clk); #1;
        wr = 1'b0;
        // Frame started at the previous edge; land inside DATA bit 3.
        repeat (16 * 4 + 7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx: got %b, required 1", tx); end
        checks++; if (busy !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL rst_mid_state: busy=%b empty=%b, required 0 1", busy, empty);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        line_high = 1; never_busy = 1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) line_high = 0;
            if (busy !== 1'b0) never_busy = 0;
        end
        checks++; if (!line_high || !never_busy || empty !== 1'b1) begin
            errors++; $display("FAIL rst_mid_after: line_high=%b never_busy=%b empty=%b, required 1 1 1", line_high, never_busy, empty);
        end
    endtask

`ifdef UART_FRAME_TX_PARITY_EN
    task automatic test_parity();
        int f0;
        bit ok;
        f0 = frames;
        baud = 1'b0;
        push_byte(8'h07, 16);
        @(posedge clk); #1;
        wr = 1'b0;
        wait_done(ok);
        push_byte(8'h03, 16);
        @(posedge clk); #1;
        wr = 1'b0;
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL parity_done: timeout, %0d bytes pending", sb.size()); end
        checks++; if (frames - f0 != 2) begin errors++; $display("FAIL parity_frames: got %0d, required 2", frames - f0); end
    endtask
`endif

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        din = 8'h00;
        wr = 1'b0;
        baud = 1'b0;
        checks = 0;
        errors = 0;
        frames = 0;
        in_frame = 0;
        fork
            monitor();
        join_none
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_baud_change();
`ifdef UART_FRAME_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Serial UART transmitter for the port-collector datapath: accepts bytes on a write strobe, buffers them in a small FIFO and shifts them out as 8-bit frames on one TX line. Timing is derived from the shared sampling clock through a per-frame baud-rate select. The collector instantiates one per output port and drives it from RAM read data.

## Interface
- FIFO_DEPTH, 4: byte FIFO depth; power of two, 2 to 16.
- CPB_SLOW, 16: i_clk cycles per bit when i_baud=0.
- CPB_FAST, 8: i_clk cycles per bit when i_baud=1.
- i_clk  in  1  sampling clock; all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_D  in  8  byte to send; sampled on the edge where i_write=1.
- i_write  in  1  push strobe, one byte per high cycle.
- i_baud  in  1  rate select, 0=CPB_SLOW, 1=CPB_FAST; sampled at frame start only.
- o_tx  out  1  serial line, idle high.
- o_busy  out  1  frame in progress (FSM not IDLE).
- o_full  out  1  FIFO holds FIFO_DEPTH bytes.
- o_empty  out  1  FIFO holds 0 bytes.
- o_overflow  out  1  one-cycle pulse: a write was dropped.

## Operation
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- Reset values: o_tx=1, o_busy=0, o_full=0, o_empty=1, o_overflow=0; FIFO count, pointers, bit counter, baud counter=0; state=IDLE.
- Push: i_write=1 and o_full=0 stores i_D at write pointer, count+1. i_write=1 and o_full=1: byte dropped, o_overflow=1 next cycle, FIFO unchanged. o_full is evaluated before any same-cycle pop.
- Pop: in IDLE with FIFO non-empty, or at the last cycle of STOP with FIFO non-empty: load head byte into 8-bit shifter, count-1, latch i_baud into CPB register, enter START.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
- Frame: START o_tx=0; DATA 8 bits LSB first; STOP o_tx=1; each bit exactly CPB cycles.
- Baud counter counts 0..CPB-1; state/bit advance when counter=CPB-1. Bit counter 0..7 in DATA; DATA to next state at bit 7 end.
- STOP end with empty FIFO: IDLE. Non-empty: START directly, no idle gap.
- i_baud changes mid-frame have no effect on the current frame.
- Reset asserted mid-frame: o_tx=1 immediately (async), FIFO flushed, partial frame abandoned.

## Timing
- o_tx registered; no combinational path from inputs to any output.
- Write at edge N into empty FIFO while IDLE: pop at edge N+1, o_tx=0 from N+1.
- Frame length: 10*CPB cycles (11*CPB with parity).
- o_busy rises with START entry, falls with IDLE entry.
- o_full/o_empty reflect count after each edge.

## Configuration
- UART_FRAME_TX_PARITY_EN defined: PARITY state between DATA and STOP, one CPB-long bit = XOR of the 8 data bits (even parity); frame 11*CPB.
- Undefined: no PARITY state, DATA goes directly to STOP; frame 10*CPB.

## Structure
- Shared package uart_pkg: FSM state enum, CPB defaults, data width constant 8; the collector's receivers use the same constants.
- Sub-module uart_tx_fifo: synchronous byte FIFO with push/pop, full/empty, count; overflow pulse generated in the top.

## Test plan
- Reset, write 0xA5, i_baud=0: o_tx = 0,1,0,1,0,0,1,0,1,1 each 16 cycles, 160 total; o_busy high exactly 160 cycles.
- Writes 0x00 then 0xFF on consecutive cycles, i_baud=1: two 80-cycle frames, no idle gap between stop of first and start of second.
- Writes on 6 consecutive cycles, FIFO_DEPTH=4: bytes 1-5 accepted, o_full=1 after 5th, 6th dropped with o_overflow one-cycle pulse; 5 frames emitted.
- i_baud toggled 0->1 in mid-frame of 0x3C: current frame stays 16 cycles/bit; next queued frame 8 cycles/bit.
- Reset pulsed during DATA bit 3: o_tx=1 during reset, o_empty=1, o_busy=0; no further frames after release.
- With UART_FRAME_TX_PARITY_EN, write 0x07: parity bit=1, frame 176 cycles at i_baud=0; 0x03 gives parity bit=0.
